// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions: FSM encodings, frame constants and baud divisor.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Clocks per bit, truncated toward zero.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with show-ahead read port; pointers wrap modulo DEPTH (power of two).
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [7:0]               din,
  input  logic                     rd_en,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic          wr_ok_s;
  logic          rd_ok_s;

  assign full    = (count == COUNT_FULL);
  assign empty   = (count == {(AW+1){1'b0}});
  assign wr_ok_s = wr_en & ~full;
  assign rd_ok_s = rd_en & ~empty;
  assign dout    = mem[rd_ptr_r];

  // Storage array, no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count    <= {(AW+1){1'b0}};
    end else begin
      if (wr_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (rd_ok_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: FIFO front end feeding a back-to-back serialiser.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 48000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       wr_en,
  output logic       full,
  output logic       overflow,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W = $clog2(CPB);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_e    state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic [IDX_W-1:0] idx_r, idx_next_s;
  logic [7:0]     shift_r, shift_next_s;
  logic           tx_next_s;
  logic           done_next_s;
  logic           pop_s;
  logic [7:0]     fifo_dout_s;
  logic [CW-1:0]  fifo_count_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .din   (data_i),
    .rd_en (pop_s),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign full = fifo_full_s;
  assign busy = (state_r != IDLE) | (fifo_count_s != {CW{1'b0}});

  // Frame sequencing; a queued byte is popped on the same edge that leaves IDLE or STOP.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    idx_next_s   = idx_r;
    shift_next_s = shift_r;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          shift_next_s = fifo_dout_s;
          cnt_next_s   = {CNT_W{1'b0}};
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == CNT_LAST) begin
          cnt_next_s   = {CNT_W{1'b0}};
          idx_next_s   = {IDX_W{1'b0}};
          state_next_s = DATA;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_next_s   = {CNT_W{1'b0}};
          shift_next_s = {1'b0, shift_r[7:1]};
          if (idx_r == IDX_LAST) begin
            state_next_s = STOP;
          end else begin
            idx_next_s = idx_r + IDX_W'(1);
          end
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_next_s = {CNT_W{1'b0}};
          if (!fifo_empty_s) begin
            pop_s        = 1'b1;
            shift_next_s = fifo_dout_s;
            state_next_s = START;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Line level and done strobe derived from the next state so both can be registered.
  always_comb begin
    tx_next_s   = LINE_IDLE;
    done_next_s = (state_next_s == STOP) && (cnt_next_s == CNT_LAST);
    case (state_next_s)
      IDLE:    tx_next_s = LINE_IDLE;
      START:   tx_next_s = START_LEVEL;
      DATA:    tx_next_s = shift_next_s[0];
      STOP:    tx_next_s = STOP_LEVEL;
      default: tx_next_s = LINE_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
      shift_r  <= 8'h00;
      tx       <= LINE_IDLE;
      tx_done  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      cnt_r    <= cnt_next_s;
      idx_r    <= idx_next_s;
      shift_r  <= shift_next_s;
      tx       <= tx_next_s;
      tx_done  <= done_next_s;
      overflow <= wr_en & fifo_full_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 10 clocks/bit (1050 Hz / 100 baud, truncated).
module tb_uart_tx_fifo;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       wr_en = 1'b0;
  logic       full, overflow, tx, busy, tx_done;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  int unsigned done_q[$];
  int unsigned start_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  int ovf_cnt = 0;
  int frame_err = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ(1050), .BAUD(100), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .wr_en(wr_en),
    .full(full), .overflow(overflow), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_q.push_back(cyc);
    if (overflow === 1'b1) ovf_cnt++;
  end

  // Serial monitor: detect start, sample mid-bit, record byte.
  initial begin : monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        start_q.push_back(cyc);
        repeat (CPB/2 - 1) @(negedge clk);
        if (tx !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) frame_err++;
        rx_q.push_back(b);
      end
    end
  end

  task automatic write_byte(input logic [7:0] d);
    wr_en  = 1'b1;
    data_i = d;
    @(negedge clk);
    wr_en  = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) check({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
    end
    rx_q.delete();
    exp_q.delete();
    done_q.delete();
    start_q.delete();
  endtask

  initial begin
    int unsigned s;
    int n;
    int lows;
    logic [7:0] d;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 0x55 frame with exact latency and length
    write_byte(8'h55);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_tx_pre", 32'(tx), 32'd1);
    @(negedge clk);
    s = cyc;
    check("t1_start", 32'(tx), 32'd0);
    repeat (CPB - 1) @(negedge clk);
    check("t1_start_end", 32'(tx), 32'd0);
    @(negedge clk);
    check("t1_bit0", 32'(tx), 32'd1);
    wait_idle(300);
    check("t1_done_cnt", 32'(done_q.size()), 32'd1);
    if (done_q.size() == 1) check("t1_done_at", done_q[0] - s, 32'(10*CPB - 1));
    exp_q.push_back(8'h55);
    compare_rx("t1_rx");

    // Three back-to-back frames
    write_byte(8'hA5);
    write_byte(8'h00);
    write_byte(8'hFF);
    wait_idle(600);
    check("t2_done_cnt", 32'(done_q.size()), 32'd3);
    if (done_q.size() == 3) begin
      check("t2_gap01", done_q[1] - done_q[0], 32'(10*CPB));
      check("t2_gap12", done_q[2] - done_q[1], 32'(10*CPB));
    end
    if (start_q.size() == 3) check("t2_start_gap", start_q[1] - start_q[0], 32'(10*CPB));
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    compare_rx("t2_rx");

    // Fill FIFO, overflow, then write on the STOP->START pop edge
    for (int k = 0; k <= 16; k++) begin
      write_byte(8'(k));
      exp_q.push_back(8'(k));
      if (k == 15) check("t3_not_full", 32'(full), 32'd0);
      if (k == 16) check("t3_full", 32'(full), 32'd1);
    end
    check("t3_no_ovf_yet", 32'(ovf_cnt), 32'd0);
    write_byte(8'h11);
    check("t3_ovf_pulse", 32'(overflow), 32'd1);
    @(negedge clk);
    check("t3_ovf_clear", 32'(overflow), 32'd0);
    check("t3_still_full", 32'(full), 32'd1);
    n = 0;
    while (tx_done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t4_done_timeout", 32'(tx_done), 32'd1);
    write_byte(8'hEE);
    check("t4_ovf", 32'(overflow), 32'd1);
    check("t4_full_drop", 32'(full), 32'd0);
    wait_idle(3000);
    compare_rx("t3_rx");

    // Reset mid-frame with bytes queued
    write_byte(8'h3C);
    write_byte(8'h01);
    write_byte(8'h02);
    repeat (40) @(negedge clk);
    done_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_tx", 32'(tx), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_full", 32'(full), 32'd0);
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("t5_quiet", 32'(lows), 32'd0);
    check("t5_no_done", 32'(done_q.size()), 32'd0);
    rx_q.delete();
    start_q.delete();
    write_byte(8'h81);
    exp_q.push_back(8'h81);
    wait_idle(300);
    compare_rx("t5_rx");

    // Random bytes with random gaps, never enough to fill the FIFO
    for (int k = 0; k < 12; k++) begin
      d = 8'($urandom_range(0, 255));
      write_byte(d);
      exp_q.push_back(d);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    wait_idle(3000);
    compare_rx("t6_rx");

    check("framing", 32'(frame_err), 32'd0);
    check("ovf_total", 32'(ovf_cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
